// File: rtl/bitty_loader_pkg.sv
// Shared definitions for the Bitty serial program loader.
// Holds the UART receiver and loader state encodings plus frame constants.
package bitty_loader_pkg;

    // state    | meaning
    // R_IDLE   | line idle, waiting for a synchronized falling edge
    // R_START  | timing to the middle of the start bit
    // R_DATA   | sampling 8 data bits, LSB first
    // R_STOP   | sampling the stop bit
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    // state    | meaning
    // L_COUNT  | waiting for the word-count byte
    // L_HI     | waiting for the high byte of a word
    // L_LO     | waiting for the low byte of a word
    // L_DONE   | one cycle after the final write; raises load_done
    typedef enum logic [1:0] {
        L_COUNT = 2'd0,
        L_HI    = 2'd1,
        L_LO    = 2'd2,
        L_DONE  = 2'd3
    } ld_state_t;

    localparam int WORD_BYTES = 2;
    localparam int MAX_WORDS  = 256;

endpackage

// File: rtl/bitty_prog_loader_if.sv
// Instruction-memory write bus and loader status, shared between the
// loader (master) and the memory/core glue (slave).
//   mem_we     one-cycle write strobe
//   mem_addr   write address, valid with mem_we
//   mem_wdata  write data {hi, lo}, valid with mem_we
//   cpu_hold   core held while a program is loading
//   load_done  one-cycle pulse after the last word is written
//   frame_err  one-cycle pulse on a bad stop bit
interface bitty_prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              frame_err;

    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, frame_err
    );

    modport slave (
        input mem_we, mem_addr, mem_wdata, cpu_hold, load_done, frame_err
    );
endinterface

// File: rtl/bitty_uart_rx.sv
// 8N1 UART byte receiver.
//   clk, reset  system clock, async active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   byte_valid  one-cycle pulse when a byte with a good stop bit arrives
//   byte_data   received byte, valid with byte_valid
//   byte_err    one-cycle pulse when the stop bit samples low
//
// state    | meaning
// R_IDLE   | line idle, waiting for a synchronized falling edge
// R_START  | timing to the middle of the start bit
// R_DATA   | sampling 8 data bits, LSB first
// R_STOP   | sampling the stop bit
module bitty_uart_rx
    import bitty_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    // Synchronizer idles high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= R_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Baud timer is a down-counter: loaded with the interval to the next
    // sample point, sample taken at terminal count zero.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = R_START;
                    baud_d  = HALF_TC;
                end
            end
            R_START: begin
                if (baud_q == '0) begin
                    if (rx_sync_q) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d = R_DATA;
                        baud_d  = FULL_TC;
                        bit_d   = 3'd0;
                    end
                end else begin
                    baud_d = baud_q - CNT_ONE;
                end
            end
            R_DATA: begin
                if (baud_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    baud_d  = FULL_TC;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end
                end else begin
                    baud_d = baud_q - CNT_ONE;
                end
            end
            R_STOP: begin
                if (baud_q == '0) begin
                    // Back to idle at mid-stop so a start bit that follows
                    // immediately is still seen as a falling edge.
                    state_d = R_IDLE;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - CNT_ONE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/bitty_prog_loader.sv
// Serial program loader for the Bitty instruction memory.
// Byte stream: count (0 means 256), then count big-endian 16-bit words,
// written to consecutive addresses from 0 while the core is held.
//   clk, reset  system clock, async active-high reset
//   rx          UART serial input (8N1)
//   bus         write bus and status (see bitty_prog_loader_if)
//
// state    | meaning
// L_COUNT  | waiting for the word-count byte
// L_HI     | waiting for the high byte of a word
// L_LO     | waiting for the low byte of a word
// L_DONE   | one cycle after the final write; raises load_done
module bitty_prog_loader
    import bitty_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    bitty_prog_loader_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;

    bitty_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_err  (byte_err)
    );

    ld_state_t         state_q, state_d;
    logic [8:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= L_COUNT;
            rem_q   <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (byte_err) begin
            // Any framing error abandons the load, including a half word.
            state_d = L_COUNT;
            hold_d  = 1'b0;
        end else begin
            case (state_q)
                L_COUNT: begin
                    if (byte_valid) begin
                        rem_d   = (byte_data == 8'd0) ? 9'(MAX_WORDS)
                                                      : {1'b0, byte_data};
                        addr_d  = '0;
                        hold_d  = 1'b1;
                        state_d = L_HI;
                    end
                end
                L_HI: begin
                    if (byte_valid) begin
                        hi_d    = byte_data;
                        state_d = L_LO;
                    end
                end
                L_LO: begin
                    if (byte_valid) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = DATA_W'({hi_q, byte_data});
                        addr_d  = addr_q + ADDR_ONE;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? L_DONE : L_HI;
                    end
                end
                L_DONE: begin
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = L_COUNT;
                end
                default: state_d = L_COUNT;
            endcase
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.load_done = done_q;
    assign bus.frame_err = byte_err;

endmodule

// File: tb/tb_bitty_prog_loader.sv
// Directed bench for bitty_prog_loader with a write scoreboard.
module tb_bitty_prog_loader;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    bitty_prog_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    bitty_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (8),
        .DATA_W      (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stop_cyc = 0;
    int   last_we_cyc = -10;
    int   n_we = 0, n_done = 0, n_ferr = 0, n_bv = 0;
    logic prev_we = 1'b0;
    wr_t  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write/done monitor; compares every strobe against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (dut.byte_valid) n_bv++;
            if (bus.frame_err) n_ferr++;
            if (bus.mem_we) begin
                wr_t e;
                n_we++;
                check("we_not_back_to_back", 32'(prev_we), 32'd0);
                check("we_under_hold", 32'(bus.cpu_hold), 32'd1);
                check("we_latency_after_stop",
                      32'((cyc - stop_cyc >= 4) && (cyc - stop_cyc <= 6)), 32'd1);
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("we_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("we_data", 32'(bus.mem_wdata), 32'(e.data));
                end
                last_we_cyc = cyc;
            end
            if (bus.load_done) begin
                n_done++;
                check("done_after_last_we", 32'(cyc - last_we_cyc), 32'd1);
                check("hold_low_at_done", 32'(bus.cpu_hold), 32'd0);
            end
            prev_we = bus.mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back('{addr: a, data: d});
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_hold"},  32'(bus.cpu_hold),  32'd0);
        check({tag, "_done"},  32'(bus.load_done), 32'd0);
        check({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        int bv0;

        // Async reset mid-cycle, then long idle line.
        #7 reset = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_no_we", 32'(n_we), 32'd0);
        check("idle_hold", 32'(bus.cpu_hold), 32'd0);

        // Two-word load.
        send_byte(8'h02);
        exp_q.push_back('{addr: 8'd0, data: 16'h1234});
        send_byte(8'h12);
        check("hold_mid_frame", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h34);
        send_word(8'd1, 16'hABCD);
        repeat (20) @(negedge clk);
        check("two_word_writes", 32'(n_we), 32'd2);
        check("two_word_done", 32'(n_done), 32'd1);
        check("two_word_sb_empty", 32'(exp_q.size()), 32'd0);
        check("two_word_hold_off", 32'(bus.cpu_hold), 32'd0);

        // Short low glitch is rejected, then a one-word load.
        bv0 = n_bv;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_byte", 32'(n_bv), 32'(bv0));
        check("glitch_no_ferr", 32'(n_ferr), 32'd0);
        check("glitch_hold", 32'(bus.cpu_hold), 32'd0);
        send_byte(8'h01);
        send_word(8'd0, 16'hFF00);
        repeat (20) @(negedge clk);
        check("one_word_writes", 32'(n_we), 32'd3);
        check("one_word_done", 32'(n_done), 32'd2);

        // Bad stop bit mid-word aborts the load.
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h77, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_pulse", 32'(n_ferr), 32'd1);
        check("ferr_no_we", 32'(n_we), 32'd3);
        check("ferr_no_done", 32'(n_done), 32'd2);
        check("ferr_hold_off", 32'(bus.cpu_hold), 32'd0);
        send_byte(8'h01);
        send_word(8'd0, 16'h2468);
        repeat (20) @(negedge clk);
        check("after_ferr_writes", 32'(n_we), 32'd4);
        check("after_ferr_done", 32'(n_done), 32'd3);

        // Count 0 means 256 words; addresses 0..255 with no wrap write.
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i), 16'(i));
        end
        repeat (120) @(negedge clk);
        check("full_writes", 32'(n_we), 32'd260);
        check("full_done", 32'(n_done), 32'd4);
        check("full_sb_empty", 32'(exp_q.size()), 32'd0);
        check("full_hold_off", 32'(bus.cpu_hold), 32'd0);

        // Reset in the middle of the second word's high byte.
        send_byte(8'h03);
        send_word(8'd0, 16'hC0DE);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        #3 reset = 1'b1;
        #1 check_outputs_zero("midreset");
        check("midreset_sb_empty", 32'(exp_q.size()), 32'd0);
        check("midreset_writes", 32'(n_we), 32'd261);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_no_we", 32'(n_we), 32'd261);
        send_byte(8'h01);
        send_word(8'd0, 16'hBEEF);
        repeat (20) @(negedge clk);
        check("post_reset_writes", 32'(n_we), 32'd262);
        check("post_reset_done", 32'(n_done), 32'd5);
        check("post_reset_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its end, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
